// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: read-owner encoding and burst counter width.
// Used with or without RAM_ARB_FAIRNESS_EN.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/naive_bus.sv
// naive_bus: independent read and write request/grant channels, 32-bit address/data, 4-bit byte enables.
// Read data returns one cycle after the read grant.
interface naive_bus;

    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        output rd_gnt, rd_data, wr_gnt
    );

endinterface

// File: rtl/ram_arb_channel.sv
// Two-way arbiter for one naive_bus channel; m0 wins unless only m1 requests.
// With RAM_ARB_FAIRNESS_EN a burst counter forces an m1 win after MAX_BURST contended m0 grants.
module ram_arb_channel #(
    parameter int MAX_BURST = 4
) (
`ifdef RAM_ARB_FAIRNESS_EN
    input  logic clk,
`endif
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic gnt,
    output logic sel,
    output logic gnt0,
    output logic gnt1
);

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("ram_arb_channel: MAX_BURST must be in 1..15");
    end

`ifdef RAM_ARB_FAIRNESS_EN
    import ram_arb_pkg::*;

    localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST);

    logic [BURST_CNT_W-1:0] burst_cnt;
    logic                   burst_full;

    assign burst_full = (burst_cnt == BURST_LIMIT);
    assign sel        = req1 & (~req0 | burst_full);

    // Counts only m0 grants taken while m1 waits; saturates so m1 wins until served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (!req1 || gnt1) begin
            burst_cnt <= '0;
        end else if (gnt0 && !burst_full) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end
`else
    assign sel = req1 & ~req0;
`endif

    assign gnt0 = rst_n & req0 & ~sel & gnt;
    assign gnt1 = rst_n & sel & gnt;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the RAM wrapper's naive_bus port between the core (m0) and the debug/loader (m1).
// Define RAM_ARB_FAIRNESS_EN to bound m1's wait to MAX_BURST+1 cycles per channel.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    naive_bus.slave  m0,
    naive_bus.slave  m1,
    naive_bus.master s
);

    logic   rd_sel;
    logic   rd_gnt0;
    logic   rd_gnt1;
    logic   wr_sel;
    logic   wr_gnt0;
    logic   wr_gnt1;
    owner_t rd_owner_q;

    ram_arb_channel #(.MAX_BURST(MAX_BURST)) u_rd_arb (
`ifdef RAM_ARB_FAIRNESS_EN
        .clk   (clk),
`endif
        .rst_n (rst_n),
        .req0  (m0.rd_req),
        .req1  (m1.rd_req),
        .gnt   (s.rd_gnt),
        .sel   (rd_sel),
        .gnt0  (rd_gnt0),
        .gnt1  (rd_gnt1)
    );

    ram_arb_channel #(.MAX_BURST(MAX_BURST)) u_wr_arb (
`ifdef RAM_ARB_FAIRNESS_EN
        .clk   (clk),
`endif
        .rst_n (rst_n),
        .req0  (m0.wr_req),
        .req1  (m1.wr_req),
        .gnt   (s.wr_gnt),
        .sel   (wr_sel),
        .gnt0  (wr_gnt0),
        .gnt1  (wr_gnt1)
    );

    assign s.rd_req  = rst_n & (m0.rd_req | m1.rd_req);
    assign s.rd_addr = rd_sel ? m1.rd_addr : m0.rd_addr;
    assign s.wr_req  = rst_n & (m0.wr_req | m1.wr_req);
    assign s.wr_addr = wr_sel ? m1.wr_addr : m0.wr_addr;
    assign s.wr_data = wr_sel ? m1.wr_data : m0.wr_data;
    assign s.wr_be   = wr_sel ? m1.wr_be   : m0.wr_be;

    assign m0.rd_gnt = rd_gnt0;
    assign m1.rd_gnt = rd_gnt1;
    assign m0.wr_gnt = wr_gnt0;
    assign m1.wr_gnt = wr_gnt1;

    // The RAM answers one cycle after the grant, so remember who asked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner_q <= OWN_NONE;
        end else if (rd_gnt0) begin
            rd_owner_q <= OWN_M0;
        end else if (rd_gnt1) begin
            rd_owner_q <= OWN_M1;
        end else begin
            rd_owner_q <= OWN_NONE;
        end
    end

    assign m0.rd_data = (rst_n && rd_owner_q == OWN_M0) ? s.rd_data : '0;
    assign m1.rd_data = (rst_n && rd_owner_q == OWN_M1) ? s.rd_data : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: table vectors, directed corner sequences and random traffic
// against a behavioural RAM-plus-arbitration model; follows RAM_ARB_FAIRNESS_EN if defined.
module tb_ram_port_arbiter;

    localparam int MAX_BURST = 4;
`ifdef RAM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    naive_bus m0_bus ();
    naive_bus m1_bus ();
    naive_bus s_bus ();

    ram_port_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus)
    );

    // RAM wrapper stand-in: registered read (old data on collision), byte-enabled write.
    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (s_bus.rd_req && s_bus.rd_gnt)
            s_bus.rd_data <= ram[s_bus.rd_addr[11:2]];
        if (s_bus.wr_req && s_bus.wr_gnt)
            for (int b = 0; b < 4; b++)
                if (s_bus.wr_be[b])
                    ram[s_bus.wr_addr[11:2]][b*8 +: 8] <= s_bus.wr_data[b*8 +: 8];
    end

    int tests = 0;
    int fails = 0;

    logic [31:0] shadow [0:1023];
    int          streak_rd, streak_wr;
    logic [31:0] exp_rd0, exp_rd1;
    logic        lg0r, lg1r, lg0w, lg1w;
    logic        obs_g0r, obs_g1r, obs_g0w, obs_g1w, obs_srq, obs_swq, obs_rsel1, obs_wsel1;
    logic [31:0] obs_rd0, obs_rd1;

    typedef struct {
        logic rr0, rr1, wr0, wr1, sgr, sgw;
        logic g0r, g1r, g0w, g1w, srq, swq, rsel1, wsel1;
    } vec_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic win1(input logic r0, input logic r1, input int streak);
        return r1 && (!r0 || (FAIR && streak >= MAX_BURST));
    endfunction

    function automatic vec_t mk(input logic [5:0] in_v, input logic [7:0] ex_v);
        vec_t v;
        {v.rr0, v.rr1, v.wr0, v.wr1, v.sgr, v.sgw} = in_v;
        {v.g0r, v.g1r, v.g0w, v.g1w, v.srq, v.swq, v.rsel1, v.wsel1} = ex_v;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        return {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    endfunction

    task automatic set_idle();
        m0_bus.rd_req = 0; m0_bus.rd_addr = '0;
        m0_bus.wr_req = 0; m0_bus.wr_addr = '0; m0_bus.wr_data = '0; m0_bus.wr_be = '0;
        m1_bus.rd_req = 0; m1_bus.rd_addr = '0;
        m1_bus.wr_req = 0; m1_bus.wr_addr = '0; m1_bus.wr_data = '0; m1_bus.wr_be = '0;
        s_bus.rd_gnt = 1; s_bus.wr_gnt = 1;
    endtask

    task automatic model_reset();
        exp_rd0 = '0; exp_rd1 = '0;
        streak_rd = 0; streak_wr = 0;
        lg0r = 0; lg1r = 0; lg0w = 0; lg1w = 0;
    endtask

    // One clock cycle: inputs already applied #1 after posedge; checks at negedge.
    task automatic run_cycle();
        logic w1r, w1w, e0r, e1r, e0w, e1w;
        logic [31:0] nxt0, nxt1, wa, wd;
        logic [3:0] wb;
        w1r = win1(m0_bus.rd_req, m1_bus.rd_req, streak_rd);
        w1w = win1(m0_bus.wr_req, m1_bus.wr_req, streak_wr);
        e0r = m0_bus.rd_req && !w1r && s_bus.rd_gnt;
        e1r = w1r && s_bus.rd_gnt;
        e0w = m0_bus.wr_req && !w1w && s_bus.wr_gnt;
        e1w = w1w && s_bus.wr_gnt;
        wa = w1w ? m1_bus.wr_addr : m0_bus.wr_addr;
        wd = w1w ? m1_bus.wr_data : m0_bus.wr_data;
        wb = w1w ? m1_bus.wr_be : m0_bus.wr_be;
        @(negedge clk);
        chk1("m0_rd_gnt", m0_bus.rd_gnt, e0r);
        chk1("m1_rd_gnt", m1_bus.rd_gnt, e1r);
        chk1("m0_wr_gnt", m0_bus.wr_gnt, e0w);
        chk1("m1_wr_gnt", m1_bus.wr_gnt, e1w);
        chk1("s_rd_req", s_bus.rd_req, m0_bus.rd_req | m1_bus.rd_req);
        chk1("s_wr_req", s_bus.wr_req, m0_bus.wr_req | m1_bus.wr_req);
        chk32("s_rd_addr", s_bus.rd_addr, w1r ? m1_bus.rd_addr : m0_bus.rd_addr);
        chk32("s_wr_addr", s_bus.wr_addr, wa);
        chk32("s_wr_data", s_bus.wr_data, wd);
        chk32("s_wr_be", {28'b0, s_bus.wr_be}, {28'b0, wb});
        chk32("m0_rd_data", m0_bus.rd_data, exp_rd0);
        chk32("m1_rd_data", m1_bus.rd_data, exp_rd1);
        obs_g0r = m0_bus.rd_gnt; obs_g1r = m1_bus.rd_gnt;
        obs_g0w = m0_bus.wr_gnt; obs_g1w = m1_bus.wr_gnt;
        obs_srq = s_bus.rd_req;  obs_swq = s_bus.wr_req;
        obs_rsel1 = (s_bus.rd_addr === m1_bus.rd_addr);
        obs_wsel1 = (s_bus.wr_addr === m1_bus.wr_addr);
        obs_rd0 = m0_bus.rd_data; obs_rd1 = m1_bus.rd_data;
        nxt0 = e0r ? shadow[m0_bus.rd_addr[11:2]] : '0;
        nxt1 = e1r ? shadow[m1_bus.rd_addr[11:2]] : '0;
        if (e0w || e1w)
            for (int b = 0; b < 4; b++)
                if (wb[b]) shadow[wa[11:2]][b*8 +: 8] = wd[b*8 +: 8];
        if (!m1_bus.rd_req || e1r) streak_rd = 0;
        else if (e0r && streak_rd < MAX_BURST) streak_rd++;
        if (!m1_bus.wr_req || e1w) streak_wr = 0;
        else if (e0w && streak_wr < MAX_BURST) streak_wr++;
        exp_rd0 = nxt0; exp_rd1 = nxt1;
        lg0r = e0r; lg1r = e1r; lg0w = e0w; lg1w = e1w;
        @(posedge clk);
        #1;
    endtask

    task automatic write_m0(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        set_idle();
        m0_bus.wr_req = 1; m0_bus.wr_addr = addr; m0_bus.wr_data = data; m0_bus.wr_be = be;
        run_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_m0_rd_gnt"}, m0_bus.rd_gnt, 1'b0);
        chk1({tag, "_m1_rd_gnt"}, m1_bus.rd_gnt, 1'b0);
        chk1({tag, "_m0_wr_gnt"}, m0_bus.wr_gnt, 1'b0);
        chk1({tag, "_m1_wr_gnt"}, m1_bus.wr_gnt, 1'b0);
        chk1({tag, "_s_rd_req"}, s_bus.rd_req, 1'b0);
        chk1({tag, "_s_wr_req"}, s_bus.wr_req, 1'b0);
        chk32({tag, "_m0_rd_data"}, m0_bus.rd_data, 32'h0);
        chk32({tag, "_m1_rd_data"}, m1_bus.rd_data, 32'h0);
    endtask

    initial begin
        vec_t vecs [8];
        int   cnt0, cnt1;

        rst_n = 0;
        set_idle();
        m0_bus.rd_req = 1; m1_bus.rd_req = 1; m0_bus.wr_req = 1; m1_bus.wr_req = 1;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1;
        set_idle();
        model_reset();

        for (int w = 0; w < 16; w++)
            write_m0(32'(w * 4), 32'h5A00_0000 | 32'(w), 4'hF);
        write_m0(32'h100, 32'h1122_3344, 4'hF);
        write_m0(32'h200, 32'hCAFE_F00D, 4'hF);

        // Inputs: rr0 rr1 wr0 wr1 sgr sgw | expected g0r g1r g0w g1w srq swq rsel1 wsel1
        vecs[0] = mk(6'b000011, 8'b00000000);
        vecs[1] = mk(6'b100111, 8'b10011101);
        vecs[2] = mk(6'b011011, 8'b01101110);
        vecs[3] = mk(6'b111111, 8'b10101100);
        vecs[4] = mk(6'b111101, 8'b00101100);
        vecs[5] = mk(6'b110110, 8'b10001101);
        vecs[6] = mk(6'b011001, 8'b00101110);
        vecs[7] = mk(6'b101100, 8'b00001100);
        for (int i = 0; i < 8; i++) begin
            set_idle();
            m0_bus.rd_addr = 32'h10;  m1_bus.rd_addr = 32'h200;
            m0_bus.wr_addr = 32'h20;  m0_bus.wr_data = 32'hA0A0_A0A0; m0_bus.wr_be = 4'hF;
            m1_bus.wr_addr = 32'h24;  m1_bus.wr_data = 32'h0B0B_0B0B; m1_bus.wr_be = 4'hF;
            m0_bus.rd_req = vecs[i].rr0; m1_bus.rd_req = vecs[i].rr1;
            m0_bus.wr_req = vecs[i].wr0; m1_bus.wr_req = vecs[i].wr1;
            s_bus.rd_gnt = vecs[i].sgr;  s_bus.wr_gnt = vecs[i].sgw;
            run_cycle();
            chk1($sformatf("vec%0d_g0r", i), obs_g0r, vecs[i].g0r);
            chk1($sformatf("vec%0d_g1r", i), obs_g1r, vecs[i].g1r);
            chk1($sformatf("vec%0d_g0w", i), obs_g0w, vecs[i].g0w);
            chk1($sformatf("vec%0d_g1w", i), obs_g1w, vecs[i].g1w);
            chk1($sformatf("vec%0d_srq", i), obs_srq, vecs[i].srq);
            chk1($sformatf("vec%0d_swq", i), obs_swq, vecs[i].swq);
            chk1($sformatf("vec%0d_rsel", i), obs_rsel1, vecs[i].rsel1);
            chk1($sformatf("vec%0d_wsel", i), obs_wsel1, vecs[i].wsel1);
        end
        set_idle();
        run_cycle();

        // Single master write then read back.
        write_m0(32'h10, 32'h1234_5678, 4'hF);
        set_idle();
        m0_bus.rd_req = 1; m0_bus.rd_addr = 32'h10;
        run_cycle();
        set_idle();
        run_cycle();
        chk32("single_m0_rd_data", obs_rd0, 32'h1234_5678);
        chk32("single_m1_rd_data", obs_rd1, 32'h0);

        // Contended reads on one channel.
        set_idle();
        run_cycle();
        cnt0 = 0; cnt1 = 0;
        set_idle();
        m0_bus.rd_req = 1; m0_bus.rd_addr = 32'h10;
        m1_bus.rd_req = 1; m1_bus.rd_addr = 32'h200;
        for (int i = 0; i < (FAIR ? 15 : 10); i++) begin
            run_cycle();
            if (obs_g0r) cnt0++;
            if (obs_g1r) cnt1++;
            if (FAIR) begin
                chk1($sformatf("fair_m1_turn%0d", i), obs_g1r, (i % 5) == 4);
                chk1($sformatf("fair_m0_turn%0d", i), obs_g0r, (i % 5) != 4);
            end
        end
        if (!FAIR) begin
            chk32("conflict_m0_gnts", 32'(cnt0), 32'd10);
            chk32("conflict_m1_gnts", 32'(cnt1), 32'd0);
        end
        set_idle();
        run_cycle();

        // Split channels: m0 byte write while m1 reads.
        set_idle();
        m0_bus.wr_req = 1; m0_bus.wr_addr = 32'h101; m0_bus.wr_data = 32'h0000_AA00; m0_bus.wr_be = 4'b0010;
        m1_bus.rd_req = 1; m1_bus.rd_addr = 32'h200;
        run_cycle();
        chk1("split_m0_wr_gnt", obs_g0w, 1'b1);
        chk1("split_m1_rd_gnt", obs_g1r, 1'b1);
        set_idle();
        m0_bus.rd_req = 1; m0_bus.rd_addr = 32'h100;
        run_cycle();
        chk32("split_m1_rd_data", obs_rd1, 32'hCAFE_F00D);
        set_idle();
        run_cycle();
        chk32("split_byte_merge", obs_rd0, 32'h1122_AA44);

        // Reset asserted during the grant cycle of an m1 read.
        set_idle();
        m1_bus.rd_req = 1; m1_bus.rd_addr = 32'h200;
        @(negedge clk);
        chk1("rst_m1_gnt_before", m1_bus.rd_gnt, 1'b1);
        rst_n = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("rst_hold");
        @(posedge clk); #1;
        rst_n = 1;
        set_idle();
        model_reset();
        run_cycle();

        // Reset asserted while read data is being returned clears it immediately.
        set_idle();
        m1_bus.rd_req = 1; m1_bus.rd_addr = 32'h200;
        run_cycle();
        m0_bus.wr_req = 1; m0_bus.wr_addr = 32'h30; m0_bus.wr_be = 4'hF;
        rst_n = 0;
        @(negedge clk);
        check_reset_outputs("rst_async");
        @(posedge clk); #1;
        rst_n = 1;
        set_idle();
        model_reset();

        // Idle.
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            chk1("idle_s_rd_req", obs_srq, 1'b0);
            chk1("idle_s_wr_req", obs_swq, 1'b0);
        end

        // Random traffic; a master not granted keeps its request unchanged.
        for (int i = 0; i < 400; i++) begin
            if (!m0_bus.rd_req || lg0r) begin
                m0_bus.rd_req = 1'($urandom_range(0, 1)); m0_bus.rd_addr = rand_addr();
            end
            if (!m1_bus.rd_req || lg1r) begin
                m1_bus.rd_req = 1'($urandom_range(0, 1)); m1_bus.rd_addr = rand_addr();
            end
            if (!m0_bus.wr_req || lg0w) begin
                m0_bus.wr_req = 1'($urandom_range(0, 1)); m0_bus.wr_addr = rand_addr();
                m0_bus.wr_data = $urandom; m0_bus.wr_be = 4'($urandom_range(1, 15));
            end
            if (!m1_bus.wr_req || lg1w) begin
                m1_bus.wr_req = 1'($urandom_range(0, 1)); m1_bus.wr_addr = rand_addr();
                m1_bus.wr_data = $urandom; m1_bus.wr_be = 4'($urandom_range(1, 15));
            end
            s_bus.rd_gnt = ($urandom_range(0, 3) != 0);
            s_bus.wr_gnt = ($urandom_range(0, 3) != 0);
            run_cycle();
        end
        set_idle();
        run_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-master arbiter that shares the single naive_bus port of the 4 kB on-chip RAM wrapper between the core data port (m0) and the UART debug/loader port (m1). Read and write channels are arbitrated independently each cycle. Read data, which the RAM returns one cycle after the grant, is steered back to the master that owned that read. The arbiter sits between the bus router's RAM slot and the RAM wrapper and adds no latency to requests.

## Interface
Parameters:
- MAX_BURST, default 4: maximum consecutive grants to m0 on one channel while m1 is waiting. Used only with fairness enabled; range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- m0  naive_bus.slave  -  core data port (rd_req/rd_gnt/rd_addr/rd_data, wr_req/wr_gnt/wr_addr/wr_data/wr_be; 32-bit address and data, 4-bit be)
- m1  naive_bus.slave  -  debug/loader port, same signal set
- s  naive_bus.master  -  to RAM wrapper

## Operation
- Read and write channels each have an independent arbiter instance. A read and a write, from the same or different masters, can both be issued in one cycle.
- Per channel, each cycle:
  - Winner is chosen from asserted reqs: default m0, or m1 if only m1 requests. Fairness rules apply when enabled.
  - s.*_req = m0.*_req | m1.*_req.
  - s address, wdata and be are muxed from the winner. When no winner, they are driven from m0.
  - Winner's gnt = s.*_gnt. The loser's gnt = 0.
  - The loser must hold req, addr, data and be stable until it is granted.
- Read return:
  - rd_owner_q (2 bits: NONE, M0, M1) is registered on every cycle in which s.rd_req & s.rd_gnt. Otherwise it is set to NONE.
  - m0.rd_data = s.rd_data when rd_owner_q == M0, else 0. Same rule for m1.
- Reset (rst_n low, at any time): rd_owner_q = NONE and burst counters = 0, both asynchronously.
  - All gnt outputs = 0, s.rd_req = s.wr_req = 0, and m*.rd_data = 0, all gated by rst_n.
  - A read granted in the cycle of reset assertion returns nothing.
- Same-cycle read and write to the same word: both pass through. Read-during-write result is defined by the RAM, not the arbiter.

## Timing
- Request to gnt: combinational, 0 cycles.
- gnt to rd_data at master: 1 cycle, i.e. valid in the cycle after gnt, for one cycle only.
- Write completes at the rising edge that ends the gnt cycle.
- Back-to-back reads alternating m0, m1, m0 are legal. rd_owner_q follows each cycle with no bubble.
- Reset outputs: all gnt 0, all rd_data 0, s.rd_req/s.wr_req 0.

## Configuration
- RAM_ARB_FAIRNESS_EN undefined: fixed priority, m0 always wins. m1 can starve indefinitely. No burst counters are synthesised.
- RAM_ARB_FAIRNESS_EN defined: per channel, a 4-bit burst_cnt counts consecutive m0 grants made while m1.req is asserted.
  - When burst_cnt == MAX_BURST and m1 requests, m1 wins that cycle.
  - Any m1 grant clears burst_cnt. Any cycle with m1.req low also clears it.
  - burst_cnt saturates at MAX_BURST.
  - Guarantees that m1 is granted within MAX_BURST+1 cycles of asserting req.

## Structure
- Package ram_arb_pkg: typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t, and the localparam BURST_CNT_W = 4.
- Sub-module ram_arb_channel: one two-way arbiter including the optional burst counter. Inputs: req0, req1, slave gnt. Outputs: sel, gnt0, gnt1. Instantiated twice (read, write). The top holds the muxes and rd_owner_q.

## Test plan
- Single master: m0 reads 0x0000_0010 after writing 0x1234_5678 with be=4'hF. m0.rd_data = 0x1234_5678 one cycle after gnt. m1.rd_data stays 0.
- Conflict, fairness off: m0 and m1 both hold rd_req for 10 cycles. m0 gets gnt all 10 cycles, m1.rd_gnt stays 0.
- Conflict, RAM_ARB_FAIRNESS_EN, MAX_BURST=4: m0 and m1 both hold rd_req continuously. Grant pattern is m0 x4, m1 x1, repeating. Each master's rd_data matches its own address's contents.
- Split channels: same cycle, m0 writes 0xAA at byte 0x0000_0101 (be=4'b0010) while m1 reads 0x0000_0200. Both are granted in that cycle. m1 receives the word at 0x200 next cycle, and word 0x100 byte 1 becomes 0xAA.
- Reset mid-read: rst_n asserted low in the cycle of m1.rd_gnt. m1.rd_data = 0 next cycle, rd_owner_q = NONE, and all gnt = 0 while reset is held.
- Idle: no reqs for 5 cycles. s.rd_req = s.wr_req = 0 and all rd_data = 0.
